// File: rtl/kulisch_accumulator.sv
// kulisch_accumulator
//   Fixed-point (Kulisch-style) accumulator. Sums a stream of aligned
//   two's-complement addends and emits one snapshot per stream on the beat
//   flagged last. Tracks sticky infinity, sticky overflow with the sign of
//   the first overflow, and a saturating beat count.
//
// Ports
//   clock, resetn         : clock, asynchronous active-low reset
//   in_valid/in_ready     : addend handshake
//   in_bits               : signed addend, binary point at ACC_FRAC
//   in_isInf              : addend is infinite (poisons the stream)
//   in_last               : final beat of the stream
//   out_valid/out_ready   : snapshot handshake
//   out_bits              : signed accumulated sum
//   out_isInf             : any beat in the stream was infinite
//   out_isOverflow        : sum left the representable range
//   out_overflowSign      : direction of the first overflow (1 = negative)
//   out_count             : beats in the stream, saturating at all-ones
module kulisch_accumulator #(
  parameter int ACC_NON_FRAC = 16,
  parameter int ACC_FRAC     = 16,
  parameter int COUNT_BITS   = 8
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ACC_NON_FRAC+ACC_FRAC:0]   in_bits,
  input  logic                             in_isInf,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_NON_FRAC+ACC_FRAC:0]   out_bits,
  output logic                             out_isInf,
  output logic                             out_isOverflow,
  output logic                             out_overflowSign,
  output logic [COUNT_BITS-1:0]            out_count
);

  localparam int TOTAL_ACC = 1 + ACC_NON_FRAC + ACC_FRAC;
  localparam int MSB       = TOTAL_ACC - 1;

  // Running stream state
  logic [MSB:0]            acc_q, acc_d;
  logic                    inf_q, inf_d;
  logic                    ovf_q, ovf_d;
  logic                    ovf_sign_q, ovf_sign_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;

  // Snapshot registers
  logic                    out_valid_q, out_valid_d;
  logic [MSB:0]            out_bits_q, out_bits_d;
  logic                    out_inf_q, out_inf_d;
  logic                    out_ovf_q, out_ovf_d;
  logic                    out_sign_q, out_sign_d;
  logic [COUNT_BITS-1:0]   out_count_q, out_count_d;

  // Per-beat combinational results
  logic                    in_fire;
  logic                    out_fire;
  logic [MSB:0]            sum;
  logic                    this_ovf;
  logic                    ovf_next;
  logic                    sign_next;
  logic                    inf_next;
  logic [COUNT_BITS-1:0]   count_next;

  always_comb begin
    in_ready = !out_valid_q || out_ready;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;

    sum      = acc_q + in_bits;
    // Equal operand signs with a differing result sign means wraparound.
    this_ovf = (acc_q[MSB] == in_bits[MSB]) && (sum[MSB] != acc_q[MSB]);
    ovf_next = ovf_q | this_ovf;
    // Only the first overflow of the stream decides the reported direction.
    if (ovf_q) begin
      sign_next = ovf_sign_q;
    end else if (this_ovf) begin
      sign_next = in_bits[MSB];
    end else begin
      sign_next = 1'b0;
    end
    inf_next   = inf_q | in_isInf;
    count_next = (count_q == '1) ? count_q : count_q + COUNT_BITS'(1);

    acc_d       = acc_q;
    inf_d       = inf_q;
    ovf_d       = ovf_q;
    ovf_sign_d  = ovf_sign_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;
    out_inf_d   = out_inf_q;
    out_ovf_d   = out_ovf_q;
    out_sign_d  = out_sign_q;
    out_count_d = out_count_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (in_last) begin
        // Last beat: result goes straight to the snapshot, stream state clears.
        // A snapshot being consumed in the same cycle is simply replaced.
        out_valid_d = 1'b1;
        out_bits_d  = sum;
        out_inf_d   = inf_next;
        out_ovf_d   = ovf_next;
        out_sign_d  = sign_next;
        out_count_d = count_next;
        acc_d       = '0;
        inf_d       = 1'b0;
        ovf_d       = 1'b0;
        ovf_sign_d  = 1'b0;
        count_d     = '0;
      end else begin
        acc_d      = sum;
        inf_d      = inf_next;
        ovf_d      = ovf_next;
        ovf_sign_d = sign_next;
        count_d    = count_next;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_q       <= '0;
      inf_q       <= 1'b0;
      ovf_q       <= 1'b0;
      ovf_sign_q  <= 1'b0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
      out_inf_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_sign_q  <= 1'b0;
      out_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      inf_q       <= inf_d;
      ovf_q       <= ovf_d;
      ovf_sign_q  <= ovf_sign_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
      out_inf_q   <= out_inf_d;
      out_ovf_q   <= out_ovf_d;
      out_sign_q  <= out_sign_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_bits         = out_bits_q;
  assign out_isInf        = out_inf_q;
  assign out_isOverflow   = out_ovf_q;
  assign out_overflowSign = out_sign_q;
  assign out_count        = out_count_q;

endmodule
